branch_update_sched: RTL and testbench
======================================

# branch_update_sched

Scheduler that shares the branch predictor's single update port between two branch-resolution requesters. Requester 0 is the ROB commit path; requester 1 is the early branch-unit resolution path. Accepted updates are buffered in a small FIFO and issued to the predictor's update inputs (branch_pc, branch_npc, actual_result, predict_update) at most one per cycle. The block also keeps wrap-around statistics counters for issued updates and mispredictions.

## Interface
- DEPTH, 4: queue capacity in entries; must be a power of 2 and at least 2. The entry being presented on upd_* counts toward capacity.
- ADDR_W, 32: PC width; matches `InstAddrBus`.
- clk  in  1  clock. One clock domain.
- rst  in  1  reset. Synchronous, active-high.
- flush  in  1  pipeline flush; discards all queued entries.
- reqN_valid  in  1  update request, for N = 0, 1.
- reqN_ready  out  1  request accepted on the edge where reqN_valid && reqN_ready.
- reqN_pc  in  ADDR_W  PC of the branch.
- reqN_npc  in  ADDR_W  resolved target.
- reqN_taken  in  1  actual direction.
- reqN_mispred  in  1  the front-end prediction was wrong.
- upd_valid  out  1  drives predict_update. Registered.
- upd_pc  out  ADDR_W  drives branch_pc. Registered.
- upd_npc  out  ADDR_W  drives branch_npc. Registered.
- upd_taken  out  1  drives actual_result. Registered.
- upd_cnt  out  32  number of issued updates.
- mispred_cnt  out  32  number of issued updates with mispred=1.

## Operation
- Occupancy `occ` ranges 0..DEPTH and includes the entry currently on upd_*. Define `free = DEPTH - occ`. A slot freed by an entry issuing this cycle is not reusable in the same cycle.
- reqN_ready is combinational from free, the priority bit `prio`, flush, and the other requester's valid:
  - flush = 1 or free = 0: both ready = 0.
  - free >= 2: both ready = 1.
  - free = 1: the requester named by `prio` gets ready = 1. The other requester gets ready = 1 only if the prio requester's valid = 0.
- Fairness:
  - When both are valid and free = 1, the winner is accepted and `prio` moves to the loser.
  - In all other cases `prio` is unchanged.
  - Reset value of `prio` is requester 0.
- Ordering:
  - Strict FIFO.
  - If both requesters are accepted on the same edge, req0's entry is placed ahead of req1's.
- Issue: whenever the queue holds an entry, the head is presented on upd_* for exactly one cycle and then retired. There is no backpressure from the predictor.
- Statistics:
  - On each cycle with upd_valid = 1, upd_cnt increments by 1.
  - mispred_cnt increments by 1 if the presented entry carries mispred = 1.
  - Both counters wrap modulo 2^32.
- Flush, effective at the next edge:
  - occ becomes 0 and pointers reset.
  - upd_valid becomes 0 in the following cycle.
  - Requests presented during the flush cycle are not accepted.
  - An entry already presented in the flush cycle still counts as issued.
  - Counters and `prio` are preserved.
- Reset:
  - upd_valid, upd_pc, upd_npc, upd_taken = 0.
  - upd_cnt, mispred_cnt = 0.
  - occ = 0, prio = requester 0.
  - Resetting mid-stream discards all entries.

## Timing
- Latency: a request accepted at edge E into an empty queue is presented (upd_valid = 1) in the cycle after E. It updates the predictor at edge E+1.
- Throughput: one issue per cycle. Sustained acceptance is limited to one per cycle once the queue is full.
- When occ = DEPTH and an entry issues, ready rises in the next cycle, not the current one.
- Counter increments are visible on the output one cycle after the corresponding upd_valid cycle.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. occ is log2(DEPTH)+1 bits.

## Structure
- config.v gains `BrQueueDepth` (4) and `BrQueueIdx`.
- The existing `InstAddrBus`, `True` and `False` macros are reused.
- Sub-module br_update_fifo: a 2-write/1-read circular buffer with payload {pc, npc, taken, mispred}, write-enable per port, and occ output.
- The top level holds the arbitration, `prio`, the output registers and the counters.

## Test plan
- Reset, then req0 with pc=0x100, npc=0x140, taken=1 → upd_valid=1 with the same values exactly one cycle after acceptance; upd_cnt=1.
- Both requesters valid for one cycle into an empty queue → both ready=1; issue order is req0 then req1 on consecutive cycles.
- Fill to DEPTH=4, then both valid continuously → at free=1 grants alternate req0, req1, req0 and so on; no entry is lost or reordered.
- Queue full while its head issues → ready stays 0 in that cycle and becomes 1 the next cycle.
- Flush with 3 queued entries and req0 valid → upd_valid=0 from the next cycle; the req0 from the flush cycle is never issued; counters keep their prior values.
- Issue 3 entries with mispred=1,0,1 → mispred_cnt=2, upd_cnt=3. Preload a counter to 0xFFFFFFFF via a long run, or force it in the bench → it wraps to 0.

Source files
------------

// File: rtl/branch_update_sched_pkg.sv
// Shared types and default sizes for the branch predictor update scheduler.
package branch_update_sched_pkg;

    // Default queue depth and PC width used by the scheduler and its FIFO.
    localparam int BR_QUEUE_DEPTH = 4;
    localparam int INST_ADDR_W    = 32;

    // Identifies one of the two update requesters.
    typedef enum logic {
        REQ0 = 1'b0,  // ROB commit path
        REQ1 = 1'b1   // early branch-unit resolution path
    } req_id_t;

    // The requester that is not r.
    function automatic req_id_t other_req(input req_id_t r);
        return (r == REQ0) ? REQ1 : REQ0;
    endfunction

endpackage

// File: rtl/br_update_fifo.sv
// Two-write / one-read circular buffer of pending predictor updates.
// The occupancy includes the entry currently being presented by the top level.
// next_valid/next_data give the head as it will be after this edge, so the
// top level can register it straight onto the predictor update port.
module br_update_fifo
    import branch_update_sched_pkg::*;
#(
    parameter int  DEPTH = BR_QUEUE_DEPTH,
    parameter int  W     = 2 * INST_ADDR_W + 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int OCC_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr0_en,
    input  logic [W-1:0]     wr0_data,
    input  logic             wr1_en,
    input  logic [W-1:0]     wr1_data,
    input  logic             rd_en,
    output logic [OCC_W-1:0] occ,
    output logic             next_valid,
    output logic [W-1:0]     next_data
);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr_nx;
    logic [PTR_W-1:0] wr1_ptr;
    logic [OCC_W-1:0] occ_left;

    // Look ahead to the head after retirement; when nothing older remains,
    // the incoming entry (port 0 first) becomes the new head directly.
    always_comb begin
        rd_ptr_nx  = rd_ptr + PTR_W'(rd_en);
        occ_left   = occ - OCC_W'(rd_en);
        wr1_ptr    = wr_ptr + PTR_W'(wr0_en);
        next_valid = 1'b0;
        next_data  = mem[rd_ptr_nx];
        if (occ_left != '0) begin
            next_valid = 1'b1;
        end else if (wr0_en) begin
            next_valid = 1'b1;
            next_data  = wr0_data;
        end else if (wr1_en) begin
            next_valid = 1'b1;
            next_data  = wr1_data;
        end
    end

    // Pointer and occupancy bookkeeping; flush empties the queue.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            rd_ptr <= rd_ptr_nx;
            wr_ptr <= wr_ptr + PTR_W'(wr0_en) + PTR_W'(wr1_en);
            occ    <= occ_left + OCC_W'(wr0_en) + OCC_W'(wr1_en);
        end
    end

    // Payload storage; port 0 lands ahead of port 1 when both write.
    always_ff @(posedge clk) begin
        if (wr0_en) mem[wr_ptr]  <= wr0_data;
        if (wr1_en) mem[wr1_ptr] <= wr1_data;
    end

endmodule

// File: rtl/branch_update_sched.sv
// Shares the branch predictor's single update port between the ROB commit
// path (req0) and the early branch-unit path (req1). Accepted updates are
// queued and issued one per cycle; issued and mispredicted counts are kept.
module branch_update_sched
    import branch_update_sched_pkg::*;
#(
    parameter int DEPTH  = BR_QUEUE_DEPTH,
    parameter int ADDR_W = INST_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_pc,
    input  logic [ADDR_W-1:0] req0_npc,
    input  logic              req0_taken,
    input  logic              req0_mispred,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_pc,
    input  logic [ADDR_W-1:0] req1_npc,
    input  logic              req1_taken,
    input  logic              req1_mispred,
    output logic              upd_valid,
    output logic [ADDR_W-1:0] upd_pc,
    output logic [ADDR_W-1:0] upd_npc,
    output logic              upd_taken,
    output logic [31:0]       upd_cnt,
    output logic [31:0]       mispred_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int PW    = 2 * ADDR_W + 2;

    logic [OCC_W-1:0]  occ;
    logic [OCC_W-1:0]  free;
    req_id_t           prio;
    logic              acc0;
    logic              acc1;
    logic              upd_mispred;
    logic              next_valid;
    logic [PW-1:0]     next_data;
    logic [ADDR_W-1:0] nx_pc;
    logic [ADDR_W-1:0] nx_npc;
    logic              nx_taken;
    logic              nx_mispred;

    assign free = OCC_W'(DEPTH) - occ;
    assign acc0 = req0_valid && req0_ready;
    assign acc1 = req1_valid && req1_ready;
    assign {nx_pc, nx_npc, nx_taken, nx_mispred} = next_data;

    br_update_fifo #(
        .DEPTH (DEPTH),
        .W     (PW)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .wr0_en     (acc0),
        .wr0_data   ({req0_pc, req0_npc, req0_taken, req0_mispred}),
        .wr1_en     (acc1),
        .wr1_data   ({req1_pc, req1_npc, req1_taken, req1_mispred}),
        .rd_en      (upd_valid),
        .occ        (occ),
        .next_valid (next_valid),
        .next_data  (next_data)
    );

    // Grant: room for two takes both; the last slot goes to prio first and
    // to the other requester only when prio is idle.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (flush || free == '0) begin
            req0_ready = 1'b0;
            req1_ready = 1'b0;
        end else if (free >= OCC_W'(2)) begin
            req0_ready = 1'b1;
            req1_ready = 1'b1;
        end else if (prio == REQ0) begin
            req0_ready = 1'b1;
            req1_ready = !req0_valid;
        end else begin
            req1_ready = 1'b1;
            req0_ready = !req1_valid;
        end
    end

    // Hand the last slot to the loser next time a contention for it occurs.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= REQ0;
        end else if (!flush && free == OCC_W'(1) && req0_valid && req1_valid) begin
            prio <= other_req(prio);
        end
    end

    // Register the next head onto the predictor update port.
    always_ff @(posedge clk) begin
        if (rst) begin
            upd_valid   <= 1'b0;
            upd_pc      <= '0;
            upd_npc     <= '0;
            upd_taken   <= 1'b0;
            upd_mispred <= 1'b0;
        end else if (flush) begin
            upd_valid   <= 1'b0;
        end else begin
            upd_valid   <= next_valid;
            upd_pc      <= nx_pc;
            upd_npc     <= nx_npc;
            upd_taken   <= nx_taken;
            upd_mispred <= nx_mispred;
        end
    end

    // Statistics; an entry presented during a flush cycle still counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            upd_cnt     <= '0;
            mispred_cnt <= '0;
        end else if (upd_valid) begin
            upd_cnt <= upd_cnt + 32'd1;
            if (upd_mispred) mispred_cnt <= mispred_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_branch_update_sched.sv
// Directed bench for branch_update_sched: a DEPTH=4 instance for the main
// scenarios and a DEPTH=2 instance where the queue can actually fill.
module tb_branch_update_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;

    logic        a0_valid, a0_ready, a0_taken, a0_mis;
    logic [31:0] a0_pc, a0_npc;
    logic        a1_valid, a1_ready, a1_taken, a1_mis;
    logic [31:0] a1_pc, a1_npc;
    logic        a_uv, a_ut;
    logic [31:0] a_upc, a_unpc, a_cnt, a_mcnt;

    logic        b0_valid, b0_ready;
    logic [31:0] b0_pc;
    logic        b1_valid, b1_ready;
    logic [31:0] b1_pc;
    logic        b_uv, b_ut;
    logic [31:0] b_upc, b_unpc, b_cnt, b_mcnt;

    int errors = 0;
    int checks = 0;
    int k0, k1;

    logic [1:0]  t3_rdy [6];
    logic [31:0] t3_pc  [8];

    always #5 clk = ~clk;

    branch_update_sched #(.DEPTH(4), .ADDR_W(32)) dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .req0_valid(a0_valid), .req0_ready(a0_ready), .req0_pc(a0_pc),
        .req0_npc(a0_npc), .req0_taken(a0_taken), .req0_mispred(a0_mis),
        .req1_valid(a1_valid), .req1_ready(a1_ready), .req1_pc(a1_pc),
        .req1_npc(a1_npc), .req1_taken(a1_taken), .req1_mispred(a1_mis),
        .upd_valid(a_uv), .upd_pc(a_upc), .upd_npc(a_unpc), .upd_taken(a_ut),
        .upd_cnt(a_cnt), .mispred_cnt(a_mcnt)
    );

    branch_update_sched #(.DEPTH(2), .ADDR_W(32)) dut_b (
        .clk(clk), .rst(rst), .flush(flush),
        .req0_valid(b0_valid), .req0_ready(b0_ready), .req0_pc(b0_pc),
        .req0_npc(32'h0), .req0_taken(1'b0), .req0_mispred(1'b0),
        .req1_valid(b1_valid), .req1_ready(b1_ready), .req1_pc(b1_pc),
        .req1_npc(32'h0), .req1_taken(1'b0), .req1_mispred(1'b0),
        .upd_valid(b_uv), .upd_pc(b_upc), .upd_npc(b_unpc), .upd_taken(b_ut),
        .upd_cnt(b_cnt), .mispred_cnt(b_mcnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        t3_rdy = '{2'b11, 2'b11, 2'b10, 2'b01, 2'b10, 2'b01};
        t3_pc  = '{32'h1000, 32'h2000, 32'h1004, 32'h2004,
                   32'h1008, 32'h2008, 32'h100C, 32'h200C};
        rst = 1'b1; flush = 1'b0;
        a0_valid = 0; a0_pc = 0; a0_npc = 0; a0_taken = 0; a0_mis = 0;
        a1_valid = 0; a1_pc = 0; a1_npc = 0; a1_taken = 0; a1_mis = 0;
        b0_valid = 0; b0_pc = 0; b1_valid = 0; b1_pc = 0;
        repeat (2) @(negedge clk);

        // reset state
        chk("rst_valid", a_uv, 0);
        chk("rst_pc", a_upc, 0);
        chk("rst_cnt", a_cnt, 0);
        chk("rst_mcnt", a_mcnt, 0);
        rst = 1'b0;
        #1 chk("rst_ready", {a0_ready, a1_ready}, 2'b11);

        // single req0 update, one-cycle latency
        a0_valid = 1; a0_pc = 32'h100; a0_npc = 32'h140; a0_taken = 1;
        @(negedge clk);
        a0_valid = 0;
        chk("t1_valid", a_uv, 1);
        chk("t1_pc", a_upc, 32'h100);
        chk("t1_npc", a_unpc, 32'h140);
        chk("t1_taken", a_ut, 1);
        chk("t1_cnt_pre", a_cnt, 0);
        @(negedge clk);
        chk("t1_idle", a_uv, 0);
        chk("t1_cnt", a_cnt, 1);

        // both requesters into an empty queue
        a0_valid = 1; a0_pc = 32'h200; a0_taken = 1;
        a1_valid = 1; a1_pc = 32'h300; a1_taken = 0;
        #1 chk("t2_ready", {a0_ready, a1_ready}, 2'b11);
        @(negedge clk);
        a0_valid = 0; a1_valid = 0;
        chk("t2_first", a_upc, 32'h200);
        @(negedge clk);
        chk("t2_second", a_upc, 32'h300);
        chk("t2_valid2", a_uv, 1);
        chk("t2_taken2", a_ut, 0);
        @(negedge clk);
        chk("t2_idle", a_uv, 0);
        chk("t2_cnt", a_cnt, 3);

        // sustained contention: last slot alternates, order preserved
        k0 = 0; k1 = 0;
        for (int i = 0; i < 10; i++) begin
            if (i >= 1 && i <= 8) begin
                chk("t3_valid", a_uv, 1);
                chk("t3_pc", a_upc, t3_pc[i-1]);
            end else begin
                chk("t3_idle", a_uv, 0);
            end
            a0_valid = (i < 6); a1_valid = (i < 6);
            a0_pc = 32'h1000 + 4 * k0;
            a1_pc = 32'h2000 + 4 * k1;
            #1;
            if (i < 6) begin
                chk("t3_ready", {a0_ready, a1_ready}, t3_rdy[i]);
                if (t3_rdy[i][1]) k0++;
                if (t3_rdy[i][0]) k1++;
            end
            @(negedge clk);
        end
        chk("t3_cnt", a_cnt, 11);

        // DEPTH=2: full while head issues, ready returns next cycle
        b0_valid = 1; b0_pc = 32'hA000; b1_valid = 1; b1_pc = 32'hB000;
        #1 chk("t4_ready_empty", {b0_ready, b1_ready}, 2'b11);
        @(negedge clk);
        #1 chk("t4_ready_full", {b0_ready, b1_ready}, 2'b00);
        chk("t4_head", b_upc, 32'hA000);
        @(negedge clk);
        b0_pc = 32'hA004;
        #1 chk("t4_ready_after", {b0_ready, b1_ready}, 2'b10);
        chk("t4_second", b_upc, 32'hB000);
        @(negedge clk);
        b0_valid = 0; b1_valid = 0;
        chk("t4_third", b_upc, 32'hA004);
        @(negedge clk);
        chk("t4_idle", b_uv, 0);

        // flush with three queued entries and req0 offering
        a0_valid = 1; a0_pc = 32'h3000; a1_valid = 1; a1_pc = 32'h4000;
        @(negedge clk);
        chk("t5_head", a_upc, 32'h3000);
        a0_pc = 32'h3004; a1_pc = 32'h4004;
        @(negedge clk);
        chk("t5_flush_head", a_upc, 32'h4000);
        chk("t5_flush_valid", a_uv, 1);
        a1_valid = 0; a0_pc = 32'h3008; flush = 1;
        #1 chk("t5_flush_ready", {a0_ready, a1_ready}, 2'b00);
        @(negedge clk);
        flush = 0; a0_valid = 0;
        chk("t5_after", a_uv, 0);
        chk("t5_cnt", a_cnt, 13);
        #1 chk("t5_ready", {a0_ready, a1_ready}, 2'b11);
        @(negedge clk);
        chk("t5_after2", a_uv, 0);
        chk("t5_cnt2", a_cnt, 13);
        chk("t5_mcnt", a_mcnt, 0);

        // reset mid-stream discards queued work
        a0_valid = 1; a0_pc = 32'h5000; a1_valid = 1; a1_pc = 32'h5004;
        @(negedge clk);
        a0_valid = 0; a1_valid = 0; rst = 1;
        chk("t6_pre", a_uv, 1);
        @(negedge clk);
        rst = 0;
        chk("t6_valid", a_uv, 0);
        chk("t6_cnt", a_cnt, 0);
        @(negedge clk);
        chk("t6_drop", a_uv, 0);

        // mispredict statistics 1,0,1
        a0_valid = 1; a0_pc = 32'h6000; a0_mis = 1;
        @(negedge clk);
        a0_pc = 32'h6004; a0_mis = 0;
        @(negedge clk);
        a0_pc = 32'h6008; a0_mis = 1;
        chk("t7_cnt1", a_cnt, 1);
        chk("t7_mcnt1", a_mcnt, 1);
        @(negedge clk);
        a0_valid = 0;
        chk("t7_cnt2", a_cnt, 2);
        chk("t7_mcnt2", a_mcnt, 1);
        @(negedge clk);
        chk("t7_cnt3", a_cnt, 3);
        chk("t7_mcnt3", a_mcnt, 2);

        // counter wrap from all-ones
        a0_valid = 1; a0_pc = 32'h7000; a0_mis = 1;
        @(negedge clk);
        a0_valid = 0;
        chk("t8_valid", a_uv, 1);
        force dut_a.upd_cnt = 32'hFFFF_FFFF;
        force dut_a.mispred_cnt = 32'hFFFF_FFFF;
        #1;
        release dut_a.upd_cnt;
        release dut_a.mispred_cnt;
        @(negedge clk);
        chk("t8_cnt_wrap", a_cnt, 0);
        chk("t8_mcnt_wrap", a_mcnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
